store_check_monitor: RTL

Multi-entry store checker for the single-cycle MIPS/FPU core. It watches the data-memory write bus (`memwrite`, `dataadr`, `writedata`) and matches observed stores against a programmable table of expected address/data pairs. It reports pass/fail with a reason code, the hit count and a timeout, in ordered or any-order mode. It sits beside `top` in benches and self-test builds, replacing single-pair ad-hoc store checks.

---
 rtl/store_check_monitor.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/store_check_monitor.sv
// Store checker for the MIPS/FPU core: matches data-memory writes against a
// programmable table of expected (address, data) pairs, reporting pass/fail.

module store_check_entry #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic [ADDR_W-1:0] dataadr,
    input  logic [DATA_W-1:0] writedata,
    output logic              addr_eq,
    output logic              data_eq
);
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_addr <= '0;
            exp_data <= '0;
        end else if (we) begin
            exp_addr <= cfg_addr;
            exp_data <= cfg_data;
        end
    end

    assign addr_eq = (dataadr == exp_addr);
    assign data_eq = (writedata == exp_data);
endmodule

module store_check_monitor #(
    parameter int N_EXP   = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1000,
    parameter int ORDERED = 1,
    parameter int STRICT  = 0,
    localparam int IDX_W  = (N_EXP > 1) ? $clog2(N_EXP) : 1,
    localparam int CNT_W  = $clog2(N_EXP) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic [CNT_W-1:0]  cfg_count,
    input  logic              start,
    input  logic [1:0]        memwrite,
    input  logic [ADDR_W-1:0] dataadr,
    input  logic [DATA_W-1:0] writedata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [1:0]        fail_code,
    output logic [CNT_W-1:0]  hit_count
);
    localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

    state_t            state;
    logic [N_EXP-1:0]  wr_en, addr_eq, data_eq, matched, hit_vec;
    logic [CNT_W-1:0]  cnt_q, cnt_in;
    logic [TMR_W-1:0]  timer, timer_nx;
    logic              cfg_ok, store, hit, fin, sfail, tmo;
    logic              cur_miss, later_hit, dup, any_amiss;
    logic [1:0]        scode;

    assign cfg_ok = cfg_we && (state != ARMED) && (32'(cfg_idx) < N_EXP);

    for (genvar g = 0; g < N_EXP; g++) begin : g_ent
        assign wr_en[g] = cfg_ok && (32'(cfg_idx) == g);
        store_check_entry #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ent (
            .clk      (clk),
            .reset    (reset),
            .we       (wr_en[g]),
            .cfg_addr (cfg_addr),
            .cfg_data (cfg_data),
            .dataadr  (dataadr),
            .writedata(writedata),
            .addr_eq  (addr_eq[g]),
            .data_eq  (data_eq[g])
        );
    end

    // Only entries below the latched count take part in matching.
    always_comb begin
        hit_vec   = '0;
        hit       = 1'b0;
        sfail     = 1'b0;
        scode     = 2'd0;
        cur_miss  = 1'b0;
        later_hit = 1'b0;
        dup       = 1'b0;
        any_amiss = 1'b0;
        if (ORDERED != 0) begin
            for (int i = 0; i < N_EXP; i++) begin
                if (i < 32'(cnt_q)) begin
                    if (i == 32'(hit_count)) begin
                        hit_vec[i] = addr_eq[i] & data_eq[i];
                        cur_miss   = addr_eq[i] & ~data_eq[i];
                    end else if (i > 32'(hit_count)) begin
                        later_hit = later_hit | (addr_eq[i] & data_eq[i]);
                    end
                end
            end
            hit   = |hit_vec;
            sfail = (STRICT != 0) && (cur_miss || later_hit);
            scode = cur_miss ? 2'd2 : 2'd3;
        end else begin
            for (int i = 0; i < N_EXP; i++) begin
                if (i < 32'(cnt_q)) begin
                    if (!matched[i] && addr_eq[i] && data_eq[i] && !hit) begin
                        hit_vec[i] = 1'b1;
                        hit        = 1'b1;
                    end
                    dup       = dup | (matched[i] & addr_eq[i] & data_eq[i]);
                    any_amiss = any_amiss | (~matched[i] & addr_eq[i]);
                end
            end
            // A repeat of an already-matched store is ignored, never a mismatch.
            sfail = (STRICT != 0) && any_amiss && !hit && !dup;
            scode = 2'd2;
        end
    end

    assign store    = |memwrite;
    assign timer_nx = timer + TMR_W'(1);
    assign fin      = store && hit && (hit_count + CNT_W'(1) == cnt_q);
    assign tmo      = (TIMEOUT != 0) && (timer_nx == TMR_W'(TIMEOUT));
    assign cnt_in   = (32'(cfg_count) > N_EXP) ? CNT_W'(N_EXP) : cfg_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt_q     <= '0;
            matched   <= '0;
            timer     <= '0;
            hit_count <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_code <= 2'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        cnt_q     <= cnt_in;
                        matched   <= '0;
                        timer     <= '0;
                        hit_count <= '0;
                        fail      <= 1'b0;
                        fail_code <= 2'd0;
                        if (cnt_in == '0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            state <= ARMED;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                            pass  <= 1'b0;
                        end
                    end
                end
                ARMED: begin
                    timer <= timer_nx;
                    if (store && hit) begin
                        hit_count <= hit_count + CNT_W'(1);
                        matched   <= matched | hit_vec;
                    end
                    // Final hit beats a strict mismatch, which beats timeout.
                    if (fin) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                    end else if (store && !hit && sfail) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        fail      <= 1'b1;
                        fail_code <= scode;
                    end else if (tmo) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        fail      <= 1'b1;
                        fail_code <= 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
